fp_unpack_pipe: RTL and testbench
=================================

Name: fp_unpack_pipe

Overview:
Registered, multi-operand floating-point unpack stage with a valid/ready handshake. It decodes NOPS operands in parallel into sign, exponent (rebiased to double), mantissa with implicit bit, and class flags, then buffers the results in a 2-entry elastic queue. It sits between the FP register-file read and the FMA/divide/convert front ends, so those units can stall without stalling operand read. It also tracks a sticky invalid flag for signaling NaNs.

Parameters:
FLEN, 64, register width in bits; must be 64.
NE, 11, output exponent width (double).
NF, 52, output fraction width (double).
NOPS, 3, number of operands decoded per transaction, range 1..4.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream transaction valid
in_ready  output  1  block can accept a transaction
in_ops  input  NOPS*FLEN  operands; operand i is at [i*FLEN +: FLEN]
in_en  input  NOPS  per-operand enable; a disabled operand decodes as +0
in_fmt  input  1  0 = single, 1 = double (applies to all operands)
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts the head entry
out_sign  output  NOPS  sign per operand
out_exp  output  NOPS*NE  biased-1023 exponent per operand
out_man  output  NOPS*(NF+1)  {implicit, fraction}, left-aligned
out_nan, out_snan, out_zero, out_inf, out_subnorm  output  NOPS each  class flags per operand
sticky_nv  output  1  set when any enabled operand is an SNaN
clr_nv  input  1  clears sticky_nv

Behaviour:
- Handshake: input is accepted when in_valid && in_ready; output is consumed when out_valid && out_ready. Payload is held stable while out_valid && !out_ready.
- Queue: 2 entries with an occupancy count of 0..2. in_ready = (count != 2) and is driven from a register. out_valid = (count != 0).
- Latency: accepted in cycle t, visible on the outputs in cycle t+1 when the queue was empty. There is no combinational in-to-out path.
- Simultaneous push and pop: the count is unchanged and order is preserved (FIFO).
- Push when full cannot occur, because in_ready is 0.
- Pop when empty is ignored.
- Decode, double (in_fmt=1): s = A[63], e = A[62:52], f = A[51:0].
- Decode, single (in_fmt=0): the operand must be NaN-boxed (A[63:32] all 1). If it is not boxed, it decodes as canonical qNaN 0x7FC00000. Then s = A[31], e8 = A[30:23], f23 = A[22:0].
- Single exponent rebias:
  - e8 = 255 gives 2047.
  - e8 = 0 with f != 0 gives 897.
  - e8 = 0 with f = 0 gives 0.
  - Otherwise e8 + 896.
- Single mantissa: f23 is placed at man[51:29] with zeros below.
- Mantissa: man = {e != 0, f}.
- Flags:
  - zero = (e == 0) && (f == 0).
  - subnorm = (e == 0) && (f != 0).
  - inf = (e all 1) && (f == 0).
  - nan = (e all 1) && (f != 0).
  - snan = nan && f MSB == 0.
  - Exactly one of {zero, subnorm, inf, nan, normal} holds per operand.
- Disabled operand (in_en[i] = 0): sign 0, exp 0, man 0, zero = 1, all other flags 0.
- sticky_nv:
  - Set on the cycle after any pop whose entry has an enabled snan bit.
  - clr_nv in the same cycle as such a pop leaves it set, because set wins.
  - Otherwise clr_nv clears it on the next edge.
- Reset (asynchronous, any time including mid-transfer):
  - count = 0, out_valid = 0, in_ready = 1 on release, sticky_nv = 0.
  - All payload outputs read 0.
  - In-flight entries are discarded.

Test Plan:
- Double 1.0 = 0x3FF0000000000000 on op0, out_ready = 1 -> next cycle: out_valid = 1, exp = 1023, man = 0x10000000000000, all flags 0 except normal.
- Single boxed 0xFFFFFFFF00000001 (min subnormal) -> exp = 897, man[51:29] = 1, implicit = 0, subnorm = 1.
- Single unboxed 0x0000000040000000 -> decodes as qNaN: nan = 1, snan = 0, exp = 2047, man = 0x18000000000000.
- Double SNaN 0x7FF0000000000001 on op1 with in_en = 3'b010 -> snan[1] = 1; sticky_nv = 1 the cycle after the pop; ops 0 and 2 read zero = 1; clr_nv then clears it.
- Backpressure: hold out_ready = 0 and push 3 transactions -> only 2 are accepted, in_ready = 0 after the second, outputs stay stable. Release out_ready -> both drain in order and in_ready returns to 1.
- Assert reset_n low with count = 2 -> out_valid drops to 0 immediately and sticky_nv = 0. After release, the first new transaction appears with 1-cycle latency.

Source files
------------

// File: rtl/fp_unpack_pipe.sv
// Multi-operand FP unpack stage: decodes NOPS single/double operands into
// sign / rebiased exponent / mantissa / class flags behind a 2-entry elastic queue.
module fp_unpack_pipe #(
  parameter int FLEN = 64,
  parameter int NE   = 11,
  parameter int NF   = 52,
  parameter int NOPS = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NOPS*FLEN-1:0]   in_ops,
  input  logic [NOPS-1:0]        in_en,
  input  logic                   in_fmt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NOPS-1:0]        out_sign,
  output logic [NOPS*NE-1:0]     out_exp,
  output logic [NOPS*(NF+1)-1:0] out_man,
  output logic [NOPS-1:0]        out_nan,
  output logic [NOPS-1:0]        out_snan,
  output logic [NOPS-1:0]        out_zero,
  output logic [NOPS-1:0]        out_inf,
  output logic [NOPS-1:0]        out_subnorm,
  output logic                   sticky_nv,
  input  logic                   clr_nv
);

  typedef struct packed {
    logic [NOPS-1:0]        sign;
    logic [NOPS*NE-1:0]     exp;
    logic [NOPS*(NF+1)-1:0] man;
    logic [NOPS-1:0]        nan;
    logic [NOPS-1:0]        snan;
    logic [NOPS-1:0]        zero;
    logic [NOPS-1:0]        inf;
    logic [NOPS-1:0]        subnorm;
  } entry_t;

  entry_t      dec;
  entry_t      slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q, in_ready_d;
  logic        nv_q, nv_d;
  logic        push, pop;

  logic [FLEN-1:0] a;
  logic [31:0]     w;
  logic            s;
  logic [NE-1:0]   e;
  logic [NF-1:0]   f;
  logic            e_zero, e_ones;

  // Classification uses the source-format exponent, so a single subnormal keeps
  // implicit bit 0 even though its rebiased exponent (897) is nonzero.
  always_comb begin
    dec    = '0;
    a      = '0;
    w      = '0;
    s      = 1'b0;
    e      = '0;
    f      = '0;
    e_zero = 1'b0;
    e_ones = 1'b0;
    for (int unsigned i = 0; i < NOPS; i++) begin
      a = in_ops[i*FLEN +: FLEN];
      if (!in_en[i]) begin
        dec.zero[i] = 1'b1;
      end else begin
        if (in_fmt) begin
          s      = a[63];
          e      = a[62:52];
          f      = a[51:0];
          e_zero = (a[62:52] == '0);
          e_ones = &a[62:52];
        end else begin
          w      = (&a[63:32]) ? a[31:0] : 32'h7FC0_0000;
          s      = w[31];
          e_zero = (w[30:23] == '0);
          e_ones = &w[30:23];
          f      = {w[22:0], 29'b0};
          if (e_ones)
            e = 11'd2047;
          else if (e_zero)
            e = (w[22:0] != '0) ? 11'd897 : 11'd0;
          else
            e = {3'b000, w[30:23]} + 11'd896;
        end
        dec.sign[i]               = s;
        dec.exp[i*NE +: NE]       = e;
        dec.man[i*(NF+1) +: NF+1] = {!e_zero, f};
        dec.zero[i]               = e_zero && (f == '0);
        dec.subnorm[i]            = e_zero && (f != '0);
        dec.inf[i]                = e_ones && (f == '0);
        dec.nan[i]                = e_ones && (f != '0);
        dec.snan[i]               = e_ones && (f != '0) && !f[NF-1];
      end
    end
  end

  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  // Head always lives in slot0 so outputs come straight from registers.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = dec;
        else                 slot1_d = dec;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = dec;
        end else begin
          slot0_d = slot1_q;
          slot1_d = dec;
        end
      end
      default: ;
    endcase
    in_ready_d = (count_d != 2'd2);
    if (pop && (slot0_q.snan != '0)) nv_d = 1'b1;
    else if (clr_nv)                 nv_d = 1'b0;
    else                             nv_d = nv_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      nv_q       <= 1'b0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      nv_q       <= nv_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_sign    = slot0_q.sign;
  assign out_exp     = slot0_q.exp;
  assign out_man     = slot0_q.man;
  assign out_nan     = slot0_q.nan;
  assign out_snan    = slot0_q.snan;
  assign out_zero    = slot0_q.zero;
  assign out_inf     = slot0_q.inf;
  assign out_subnorm = slot0_q.subnorm;
  assign sticky_nv   = nv_q;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed bench for fp_unpack_pipe: decode patterns, queue backpressure,
// sticky invalid flag and asynchronous reset with hand-computed expectations.
module tb_fp_unpack_pipe;

  localparam int NOPS = 3;
  localparam int NE   = 11;
  localparam int NF   = 52;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid, in_ready;
  logic [NOPS*64-1:0] in_ops;
  logic [NOPS-1:0]    in_en;
  logic               in_fmt;
  logic               out_valid, out_ready;
  logic [NOPS-1:0]    out_sign;
  logic [NOPS*NE-1:0] out_exp;
  logic [NOPS*(NF+1)-1:0] out_man;
  logic [NOPS-1:0]    out_nan, out_snan, out_zero, out_inf, out_subnorm;
  logic               sticky_nv, clr_nv;

  int n_err = 0;
  int n_chk = 0;

  fp_unpack_pipe #(.FLEN(64), .NE(NE), .NF(NF), .NOPS(NOPS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops), .in_en(in_en), .in_fmt(in_fmt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
    .out_nan(out_nan), .out_snan(out_snan), .out_zero(out_zero), .out_inf(out_inf),
    .out_subnorm(out_subnorm), .sticky_nv(sticky_nv), .clr_nv(clr_nv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ex(int i);
    return 64'(out_exp[i*NE +: NE]);
  endfunction

  function automatic logic [63:0] mn(int i);
    return 64'(out_man[i*(NF+1) +: NF+1]);
  endfunction

  // {nan, snan, zero, inf, subnorm}
  function automatic logic [63:0] fl(int i);
    return 64'({out_nan[i], out_snan[i], out_zero[i], out_inf[i], out_subnorm[i]});
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_ops = '0; in_en = '0; in_fmt = 1'b1;
    out_ready = 1'b0; clr_nv = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sticky", 64'(sticky_nv), 64'd0);
    chk("rst_man_zero", 64'(|out_man), 64'd0);
    chk("rst_exp_zero", 64'(|out_exp), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    // Double 1.0 on op0, others disabled
    in_fmt = 1'b1; in_en = 3'b001; out_ready = 1'b1; in_valid = 1'b1;
    in_ops = {64'h0, 64'h0, 64'h3FF0_0000_0000_0000};
    tick(); in_valid = 1'b0;
    chk("d1_valid", 64'(out_valid), 64'd1);
    chk("d1_exp", ex(0), 64'd1023);
    chk("d1_man", mn(0), 64'h0010_0000_0000_0000);
    chk("d1_flags", fl(0), 64'd0);
    chk("d1_sign", 64'(out_sign), 64'd0);
    chk("d1_zero_dis", 64'(out_zero), 64'b110);
    tick();
    chk("d1_drained", 64'(out_valid), 64'd0);

    // Singles: min subnormal, unboxed -> qNaN, boxed -2.0
    in_fmt = 1'b0; in_en = 3'b111; in_valid = 1'b1;
    in_ops = {64'hFFFF_FFFF_C000_0000, 64'h0000_0000_4000_0000, 64'hFFFF_FFFF_0000_0001};
    tick(); in_valid = 1'b0;
    chk("s_sub_exp", ex(0), 64'd897);
    chk("s_sub_man", mn(0), 64'h0000_0000_2000_0000);
    chk("s_sub_flags", fl(0), 64'b00001);
    chk("s_unbox_exp", ex(1), 64'd2047);
    chk("s_unbox_man", mn(1), 64'h0018_0000_0000_0000);
    chk("s_unbox_flags", fl(1), 64'b10000);
    chk("s_neg2_exp", ex(2), 64'd1024);
    chk("s_neg2_man", mn(2), 64'h0010_0000_0000_0000);
    chk("s_neg2_flags", fl(2), 64'd0);
    chk("s_sign", 64'(out_sign), 64'b100);
    tick();

    // Doubles: +inf, -0, min subnormal
    in_fmt = 1'b1; in_en = 3'b111; in_valid = 1'b1;
    in_ops = {64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000};
    tick(); in_valid = 1'b0;
    chk("d_inf_exp", ex(0), 64'd2047);
    chk("d_inf_man", mn(0), 64'h0010_0000_0000_0000);
    chk("d_inf_flags", fl(0), 64'b00010);
    chk("d_nz_flags", fl(1), 64'b00100);
    chk("d_nz_exp", ex(1), 64'd0);
    chk("d_sub_man", mn(2), 64'd1);
    chk("d_sub_flags", fl(2), 64'b00001);
    chk("d_sign", 64'(out_sign), 64'b010);
    tick();

    // Double SNaN on op1 only; disabled operands carry nonzero data
    in_en = 3'b010; in_valid = 1'b1;
    in_ops = {64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000};
    tick(); in_valid = 1'b0;
    chk("snan_flags1", fl(1), 64'b11000);
    chk("snan_man1", mn(1), 64'h0010_0000_0000_0001);
    chk("snan_zero_dis", 64'(out_zero), 64'b101);
    chk("snan_dis_exp0", ex(0), 64'd0);
    chk("snan_dis_man2", mn(2), 64'd0);
    chk("snan_sticky_pre", 64'(sticky_nv), 64'd0);
    tick();
    chk("snan_sticky_set", 64'(sticky_nv), 64'd1);
    chk("snan_drained", 64'(out_valid), 64'd0);
    clr_nv = 1'b1;
    tick();
    chk("nv_cleared", 64'(sticky_nv), 64'd0);

    // Single SNaN; clear held through the pop, set must win
    in_fmt = 1'b0; in_en = 3'b001; in_valid = 1'b1;
    in_ops = {64'h0, 64'h0, 64'hFFFF_FFFF_7F80_0001};
    tick(); in_valid = 1'b0;
    chk("ssnan_exp", ex(0), 64'd2047);
    chk("ssnan_man", mn(0), 64'h0010_0000_2000_0000);
    chk("ssnan_flags", fl(0), 64'b11000);
    chk("ssnan_sticky_pre", 64'(sticky_nv), 64'd0);
    tick();
    chk("nv_set_wins", 64'(sticky_nv), 64'd1);
    clr_nv = 1'b0;

    // Backpressure: three pushes, only two accepted
    in_fmt = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    in_ops = {64'h0, 64'h0, 64'h4000_0000_0000_0000};
    tick();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    chk("bp_valid1", 64'(out_valid), 64'd1);
    in_ops = {64'h0, 64'h0, 64'h4008_0000_0000_0000};
    tick();
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    chk("bp_head_man", mn(0), 64'h0010_0000_0000_0000);
    in_ops = {64'h0, 64'h0, 64'h4010_0000_0000_0000};
    tick();
    chk("bp_ready_hold", 64'(in_ready), 64'd0);
    chk("bp_head_exp_hold", ex(0), 64'd1024);
    chk("bp_head_man_hold", mn(0), 64'h0010_0000_0000_0000);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_2nd_man", mn(0), 64'h0018_0000_0000_0000);
    chk("bp_2nd_exp", ex(0), 64'd1024);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    chk("bp_2nd_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("nv_retained", 64'(sticky_nv), 64'd1);

    // Reset with a full queue
    out_ready = 1'b0; in_valid = 1'b1;
    in_ops = {64'h0, 64'h0, 64'h4000_0000_0000_0000};
    tick(); tick();
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_sticky", 64'(sticky_nv), 64'd0);
    chk("arst_man_zero", 64'(|out_man), 64'd0);
    #3;
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b1; in_valid = 1'b1;
    in_ops = {64'h0, 64'h0, 64'hBFF8_0000_0000_0000};
    tick(); in_valid = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_sign", 64'(out_sign), 64'b001);
    chk("post_rst_exp", ex(0), 64'd1023);
    chk("post_rst_man", mn(0), 64'h0018_0000_0000_0000);
    tick();
    chk("post_rst_drained", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
